// File: rtl/easyaxi_slv_rd_pkg.sv
// Shared AXI widths, response codes and R-channel state encoding for the
// easyaxi read-slave responder.
package easyaxi_slv_rd_pkg;

  localparam int unsigned AXI_ID_WIDTH   = 4;
  localparam int unsigned AXI_ADDR_WIDTH = 16;
  localparam int unsigned AXI_DATA_WIDTH = 32;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  // Countdown register width; covers the full 1..15 latency range.
  localparam int unsigned CD_WIDTH = 4;

  typedef enum logic {
    R_IDLE  = 1'b0,
    R_VALID = 1'b1
  } r_state_e;

endpackage

// File: rtl/easyaxi_slv_rd_if.sv
// AR/R channel bundle between the read master and the read-slave responder.
interface easyaxi_slv_rd_if #(
  parameter int unsigned ID_WIDTH   = easyaxi_slv_rd_pkg::AXI_ID_WIDTH,
  parameter int unsigned ADDR_WIDTH = easyaxi_slv_rd_pkg::AXI_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = easyaxi_slv_rd_pkg::AXI_DATA_WIDTH
) ();

  logic                  axi_slv_arvalid;
  logic                  axi_slv_arready;
  logic [ID_WIDTH-1:0]   axi_slv_arid;
  logic [ADDR_WIDTH-1:0] axi_slv_araddr;
  logic                  axi_slv_rvalid;
  logic                  axi_slv_rready;
  logic [ID_WIDTH-1:0]   axi_slv_rid;
  logic [DATA_WIDTH-1:0] axi_slv_rdata;
  logic [1:0]            axi_slv_rresp;
  logic                  axi_slv_rlast;

  modport master (
    output axi_slv_arvalid, axi_slv_arid, axi_slv_araddr, axi_slv_rready,
    input  axi_slv_arready, axi_slv_rvalid, axi_slv_rid, axi_slv_rdata,
           axi_slv_rresp, axi_slv_rlast
  );

  modport slave (
    input  axi_slv_arvalid, axi_slv_arid, axi_slv_araddr, axi_slv_rready,
    output axi_slv_arready, axi_slv_rvalid, axi_slv_rid, axi_slv_rdata,
           axi_slv_rresp, axi_slv_rlast
  );

endinterface

// File: rtl/easyaxi_slv_rd_sync_fifo.sv
// In-order request store with push/pop, count, full/empty, and a
// combinational peek port so the owner can look ahead at the next head.
module easyaxi_sync_fifo #(
  parameter int unsigned WIDTH = 22,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  input  logic [$clog2(DEPTH)-1:0] i_peek_idx,
  output logic [WIDTH-1:0]         o_peek_data,
  output logic [$clog2(DEPTH)-1:0] o_wr_idx,
  output logic [$clog2(DEPTH)-1:0] o_rd_idx,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Storage, pointers and occupancy; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
    end
  end

  // Status and peek read-out.
  always_comb begin
    o_peek_data = r_mem[i_peek_idx];
    o_wr_idx    = r_wr_ptr;
    o_rd_idx    = r_rd_ptr;
    o_count     = r_count;
    o_full      = (r_count == CNT_W'(DEPTH));
    o_empty     = (r_count == '0);
  end

endmodule

// File: rtl/easyaxi_slv_rd.sv
// AXI read-slave responder: accepts AR requests into an in-order buffer and
// answers each with a single-beat R response after a fixed latency. Data is
// {zeros, arid, araddr}; addresses at or above ADDR_LIMIT return SLVERR.
module easyaxi_slv_rd #(
  parameter int unsigned AXI_ID_WIDTH   = easyaxi_slv_rd_pkg::AXI_ID_WIDTH,
  parameter int unsigned AXI_ADDR_WIDTH = easyaxi_slv_rd_pkg::AXI_ADDR_WIDTH,
  parameter int unsigned AXI_DATA_WIDTH = easyaxi_slv_rd_pkg::AXI_DATA_WIDTH,
  parameter int unsigned OST_DEPTH      = 4,
  parameter int unsigned RD_LATENCY     = 2,
  parameter logic [AXI_ADDR_WIDTH-1:0] ADDR_LIMIT = 'h0001
) (
  input  logic                         clk,
  input  logic                         rst_n,
  easyaxi_slv_rd_if.slave              axi_slv,
  output logic [$clog2(OST_DEPTH):0]   ost_cnt
);

  import easyaxi_slv_rd_pkg::*;

  localparam int unsigned PTR_W   = $clog2(OST_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned ENTRY_W = AXI_ID_WIDTH + AXI_ADDR_WIDTH + 2;
  localparam logic [CD_WIDTH-1:0] CD_INIT = CD_WIDTH'(RD_LATENCY - 1);

  r_state_e                  r_state;
  r_state_e                  w_state_next;

  logic [CD_WIDTH-1:0]       r_cd      [OST_DEPTH];
  logic [CD_WIDTH-1:0]       w_cd_next [OST_DEPTH];

  logic [AXI_ID_WIDTH-1:0]   r_rid;
  logic [AXI_DATA_WIDTH-1:0] r_rdata;
  logic [1:0]                r_rresp;

  logic                      w_arready;
  logic                      w_push;
  logic                      w_pop;
  logic [1:0]                w_ar_resp;
  logic [ENTRY_W-1:0]        w_push_data;
  logic                      w_full;
  logic                      w_empty;
  logic [CNT_W-1:0]          w_count;
  logic [PTR_W-1:0]          w_wr_idx;
  logic [PTR_W-1:0]          w_rd_idx;
  logic [PTR_W-1:0]          w_head_next_idx;
  logic [ENTRY_W-1:0]        w_peek_data;
  logic [ENTRY_W-1:0]        w_head_next_data;
  logic [CNT_W-1:0]          w_cnt_after_pop;
  logic [CNT_W-1:0]          w_cnt_next;
  logic                      w_head_ready;
  logic [AXI_ID_WIDTH-1:0]   w_next_id;
  logic [AXI_ADDR_WIDTH-1:0] w_next_addr;
  logic [1:0]                w_next_resp;

  easyaxi_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (OST_DEPTH)
  ) u_fifo (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_push      (w_push),
    .i_wdata     (w_push_data),
    .i_pop       (w_pop),
    .i_peek_idx  (w_head_next_idx),
    .o_peek_data (w_peek_data),
    .o_wr_idx    (w_wr_idx),
    .o_rd_idx    (w_rd_idx),
    .o_count     (w_count),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  // AR acceptance and request decode; arready depends on registered state only.
  always_comb begin
    w_arready   = rst_n & ~w_full;
    w_push      = axi_slv.axi_slv_arvalid & w_arready;
    w_pop       = (r_state == R_VALID) & axi_slv.axi_slv_rready & ~w_empty;
    w_ar_resp   = (axi_slv.axi_slv_araddr < ADDR_LIMIT) ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
    w_push_data = {axi_slv.axi_slv_arid, axi_slv.axi_slv_araddr, w_ar_resp};
  end

  // Next countdown per slot: saturating decrement, reload on push into that slot.
  always_comb begin
    for (int unsigned i = 0; i < OST_DEPTH; i++) begin
      w_cd_next[i] = (r_cd[i] == '0) ? '0 : r_cd[i] - CD_WIDTH'(1);
      if (w_push && (w_wr_idx == PTR_W'(i))) begin
        w_cd_next[i] = CD_INIT;
      end
    end
  end

  // Countdown registers indexed by FIFO storage slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < OST_DEPTH; i++) begin
        r_cd[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < OST_DEPTH; i++) begin
        r_cd[i] <= w_cd_next[i];
      end
    end
  end

  // Look ahead to the head entry after this edge so rvalid and the payload
  // can be registered; when the buffer drains to nothing but the incoming
  // push, that push is the next head and is not yet in storage.
  always_comb begin
    w_cnt_after_pop  = w_count - CNT_W'(w_pop);
    w_cnt_next       = w_cnt_after_pop + CNT_W'(w_push);
    w_head_next_idx  = w_rd_idx + PTR_W'(w_pop);
    w_head_next_data = (w_cnt_after_pop == '0) ? w_push_data : w_peek_data;
    w_head_ready     = (w_cnt_next != '0) && (w_cd_next[w_head_next_idx] == '0);
    w_next_id        = w_head_next_data[ENTRY_W-1 -: AXI_ID_WIDTH];
    w_next_addr      = w_head_next_data[2 +: AXI_ADDR_WIDTH];
    w_next_resp      = w_head_next_data[1:0];
  end

  // R-channel state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= R_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // R-channel next state: valid whenever the upcoming head has matured.
  always_comb begin
    w_state_next = R_IDLE;
    if (w_head_ready) begin
      w_state_next = R_VALID;
    end
  end

  // R payload registers; reload only when a response will be presented.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rid   <= '0;
      r_rdata <= '0;
      r_rresp <= '0;
    end else if (w_state_next == R_VALID) begin
      r_rid   <= w_next_id;
      r_rdata <= AXI_DATA_WIDTH'({w_next_id, w_next_addr});
      r_rresp <= w_next_resp;
    end
  end

  // Drive the bus.
  always_comb begin
    axi_slv.axi_slv_arready = w_arready;
    axi_slv.axi_slv_rvalid  = (r_state == R_VALID);
    axi_slv.axi_slv_rid     = r_rid;
    axi_slv.axi_slv_rdata   = r_rdata;
    axi_slv.axi_slv_rresp   = r_rresp;
    axi_slv.axi_slv_rlast   = 1'b1;
    ost_cnt                 = w_count;
  end

endmodule

// File: tb/tb_easyaxi_slv_rd.sv
// Directed self-checking bench for easyaxi_slv_rd (RD_LATENCY=2, OST_DEPTH=4).
module tb_easyaxi_slv_rd;

  logic       clk;
  logic       rst_n;
  logic [2:0] ost_cnt;
  int         checks;
  int         errors;

  easyaxi_slv_rd_if #(
    .ID_WIDTH   (4),
    .ADDR_WIDTH (16),
    .DATA_WIDTH (32)
  ) u_if ();

  easyaxi_slv_rd #(
    .AXI_ID_WIDTH   (4),
    .AXI_ADDR_WIDTH (16),
    .AXI_DATA_WIDTH (32),
    .OST_DEPTH      (4),
    .RD_LATENCY     (2),
    .ADDR_LIMIT     (16'h0001)
  ) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .axi_slv (u_if),
    .ost_cnt (ost_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    u_if.axi_slv_arvalid = 1'b0;
    u_if.axi_slv_arid    = '0;
    u_if.axi_slv_araddr  = '0;
    u_if.axi_slv_rready  = 1'b0;
    tick(); tick(); tick();
    checks++; if (u_if.axi_slv_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %0h exp 0", u_if.axi_slv_rvalid); end
    checks++; if (u_if.axi_slv_rid !== 4'h0) begin errors++; $display("FAIL reset_rid got %0h exp 0", u_if.axi_slv_rid); end
    checks++; if (u_if.axi_slv_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %0h exp 0", u_if.axi_slv_rdata); end
    checks++; if (u_if.axi_slv_rresp !== 2'b00) begin errors++; $display("FAIL reset_rresp got %0h exp 0", u_if.axi_slv_rresp); end
    checks++; if (ost_cnt !== 3'd0) begin errors++; $display("FAIL reset_ost_cnt got %0d exp 0", ost_cnt); end
    checks++; if (u_if.axi_slv_arready !== 1'b0) begin errors++; $display("FAIL reset_arready got %0h exp 0", u_if.axi_slv_arready); end
    rst_n = 1'b1;
    #1;
    checks++; if (u_if.axi_slv_arready !== 1'b1) begin errors++; $display("FAIL release_arready got %0h exp 1", u_if.axi_slv_arready); end
  endtask

  task automatic test_single;
    u_if.axi_slv_arid    = 4'h3;
    u_if.axi_slv_araddr  = 16'h0000;
    u_if.axi_slv_arvalid = 1'b1;
    u_if.axi_slv_rready  = 1'b1;
    #1;
    checks++; if (u_if.axi_slv_arready !== 1'b1) begin errors++; $display("FAIL single_arready got %0h exp 1", u_if.axi_slv_arready); end
    tick();
    u_if.axi_slv_arvalid = 1'b0;
    checks++; if (u_if.axi_slv_rvalid !== 1'b0) begin errors++; $display("FAIL single_early_rvalid got %0h exp 0", u_if.axi_slv_rvalid); end
    checks++; if (ost_cnt !== 3'd1) begin errors++; $display("FAIL single_ost_cnt got %0d exp 1", ost_cnt); end
    tick();
    checks++; if (u_if.axi_slv_rvalid !== 1'b1) begin errors++; $display("FAIL single_rvalid got %0h exp 1", u_if.axi_slv_rvalid); end
    checks++; if (u_if.axi_slv_rid !== 4'h3) begin errors++; $display("FAIL single_rid got %0h exp 3", u_if.axi_slv_rid); end
    checks++; if (u_if.axi_slv_rdata !== 32'h0003_0000) begin errors++; $display("FAIL single_rdata got %0h exp 00030000", u_if.axi_slv_rdata); end
    checks++; if (u_if.axi_slv_rresp !== 2'b00) begin errors++; $display("FAIL single_rresp got %0h exp 0", u_if.axi_slv_rresp); end
    checks++; if (u_if.axi_slv_rlast !== 1'b1) begin errors++; $display("FAIL single_rlast got %0h exp 1", u_if.axi_slv_rlast); end
    tick();
    checks++; if (u_if.axi_slv_rvalid !== 1'b0) begin errors++; $display("FAIL single_rvalid_drop got %0h exp 0", u_if.axi_slv_rvalid); end
    checks++; if (ost_cnt !== 3'd0) begin errors++; $display("FAIL single_ost_drain got %0d exp 0", ost_cnt); end
  endtask

  task automatic test_error_decode;
    u_if.axi_slv_arid    = 4'hA;
    u_if.axi_slv_araddr  = 16'h0001;
    u_if.axi_slv_arvalid = 1'b1;
    u_if.axi_slv_rready  = 1'b1;
    tick();
    u_if.axi_slv_arvalid = 1'b0;
    tick();
    checks++; if (u_if.axi_slv_rvalid !== 1'b1) begin errors++; $display("FAIL err_rvalid got %0h exp 1", u_if.axi_slv_rvalid); end
    checks++; if (u_if.axi_slv_rresp !== 2'b10) begin errors++; $display("FAIL err_rresp got %0h exp 2", u_if.axi_slv_rresp); end
    checks++; if (u_if.axi_slv_rdata !== 32'h000A_0001) begin errors++; $display("FAIL err_rdata got %0h exp 000a0001", u_if.axi_slv_rdata); end
    tick();
    checks++; if (u_if.axi_slv_rvalid !== 1'b0) begin errors++; $display("FAIL err_rvalid_drop got %0h exp 0", u_if.axi_slv_rvalid); end
  endtask

  task automatic test_fill_full;
    logic [3:0] k4;
    u_if.axi_slv_rready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      k4 = 4'(i);
      u_if.axi_slv_arid    = k4;
      u_if.axi_slv_araddr  = 16'h0020 + 16'(i);
      u_if.axi_slv_arvalid = 1'b1;
      tick();
    end
    u_if.axi_slv_arvalid = 1'b0;
    #1;
    checks++; if (ost_cnt !== 3'd4) begin errors++; $display("FAIL full_ost_cnt got %0d exp 4", ost_cnt); end
    checks++; if (u_if.axi_slv_arready !== 1'b0) begin errors++; $display("FAIL full_arready got %0h exp 0", u_if.axi_slv_arready); end
    u_if.axi_slv_arid    = 4'hF;
    u_if.axi_slv_arvalid = 1'b1;
    tick();
    u_if.axi_slv_arvalid = 1'b0;
    checks++; if (ost_cnt !== 3'd4) begin errors++; $display("FAIL full_no_accept got %0d exp 4", ost_cnt); end
    checks++; if (u_if.axi_slv_rvalid !== 1'b1) begin errors++; $display("FAIL full_rvalid got %0h exp 1", u_if.axi_slv_rvalid); end
    u_if.axi_slv_rready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      k4 = 4'(k);
      checks++; if (u_if.axi_slv_rvalid !== 1'b1) begin errors++; $display("FAIL drain_rvalid[%0d] got %0h exp 1", k, u_if.axi_slv_rvalid); end
      checks++; if (u_if.axi_slv_rid !== k4) begin errors++; $display("FAIL drain_rid[%0d] got %0h exp %0h", k, u_if.axi_slv_rid, k4); end
      tick();
      if (k == 0) begin
        checks++; if (u_if.axi_slv_arready !== 1'b1) begin errors++; $display("FAIL drain_arready got %0h exp 1", u_if.axi_slv_arready); end
      end
    end
    checks++; if (u_if.axi_slv_rvalid !== 1'b0) begin errors++; $display("FAIL drain_done_rvalid got %0h exp 0", u_if.axi_slv_rvalid); end
    checks++; if (ost_cnt !== 3'd0) begin errors++; $display("FAIL drain_done_ost got %0d exp 0", ost_cnt); end
  endtask

  task automatic test_backpressure;
    u_if.axi_slv_rready  = 1'b0;
    u_if.axi_slv_arid    = 4'h5;
    u_if.axi_slv_araddr  = 16'h0007;
    u_if.axi_slv_arvalid = 1'b1;
    tick();
    u_if.axi_slv_arvalid = 1'b0;
    tick();
    for (int c = 0; c < 5; c++) begin
      checks++; if (u_if.axi_slv_rvalid !== 1'b1) begin errors++; $display("FAIL hold_rvalid[%0d] got %0h exp 1", c, u_if.axi_slv_rvalid); end
      checks++; if (u_if.axi_slv_rid !== 4'h5) begin errors++; $display("FAIL hold_rid[%0d] got %0h exp 5", c, u_if.axi_slv_rid); end
      checks++; if (u_if.axi_slv_rdata !== 32'h0005_0007) begin errors++; $display("FAIL hold_rdata[%0d] got %0h exp 00050007", c, u_if.axi_slv_rdata); end
      checks++; if (u_if.axi_slv_rresp !== 2'b10) begin errors++; $display("FAIL hold_rresp[%0d] got %0h exp 2", c, u_if.axi_slv_rresp); end
      tick();
    end
    u_if.axi_slv_rready = 1'b1;
    tick();
    checks++; if (u_if.axi_slv_rvalid !== 1'b0) begin errors++; $display("FAIL hold_release got %0h exp 0", u_if.axi_slv_rvalid); end
  endtask

  task automatic test_back_to_back;
    logic [3:0]  k4;
    logic [15:0] ea;
    logic [31:0] ed;
    u_if.axi_slv_rready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      k4 = 4'(c);
      u_if.axi_slv_arvalid = (c < 16);
      u_if.axi_slv_arid    = k4;
      u_if.axi_slv_araddr  = 16'h0100 + 16'(c);
      checks++; if (u_if.axi_slv_arready !== 1'b1) begin errors++; $display("FAIL stream_arready[%0d] got %0h exp 1", c, u_if.axi_slv_arready); end
      if (c >= 2 && c < 18) begin
        k4 = 4'(c - 2);
        ea = 16'h0100 + 16'(c - 2);
        ed = {12'h000, k4, ea};
        checks++; if (u_if.axi_slv_rvalid !== 1'b1) begin errors++; $display("FAIL stream_rvalid[%0d] got %0h exp 1", c, u_if.axi_slv_rvalid); end
        checks++; if (u_if.axi_slv_rid !== k4) begin errors++; $display("FAIL stream_rid[%0d] got %0h exp %0h", c, u_if.axi_slv_rid, k4); end
        checks++; if (u_if.axi_slv_rdata !== ed) begin errors++; $display("FAIL stream_rdata[%0d] got %0h exp %0h", c, u_if.axi_slv_rdata, ed); end
        checks++; if (u_if.axi_slv_rresp !== 2'b10) begin errors++; $display("FAIL stream_rresp[%0d] got %0h exp 2", c, u_if.axi_slv_rresp); end
      end else begin
        checks++; if (u_if.axi_slv_rvalid !== 1'b0) begin errors++; $display("FAIL stream_idle_rvalid[%0d] got %0h exp 0", c, u_if.axi_slv_rvalid); end
      end
      if (c >= 2 && c <= 16) begin
        checks++; if (ost_cnt !== 3'd2) begin errors++; $display("FAIL stream_ost[%0d] got %0d exp 2", c, ost_cnt); end
      end
      tick();
    end
    u_if.axi_slv_arvalid = 1'b0;
    checks++; if (ost_cnt !== 3'd0) begin errors++; $display("FAIL stream_end_ost got %0d exp 0", ost_cnt); end
  endtask

  task automatic test_reset_mid;
    u_if.axi_slv_rready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      u_if.axi_slv_arid    = 4'(7 + i);
      u_if.axi_slv_araddr  = 16'h0000;
      u_if.axi_slv_arvalid = 1'b1;
      tick();
    end
    u_if.axi_slv_arvalid = 1'b0;
    tick();
    checks++; if (ost_cnt !== 3'd3) begin errors++; $display("FAIL mid_ost_before got %0d exp 3", ost_cnt); end
    checks++; if (u_if.axi_slv_rvalid !== 1'b1) begin errors++; $display("FAIL mid_rvalid_before got %0h exp 1", u_if.axi_slv_rvalid); end
    rst_n = 1'b0;
    #1;
    checks++; if (u_if.axi_slv_arready !== 1'b0) begin errors++; $display("FAIL mid_arready_low got %0h exp 0", u_if.axi_slv_arready); end
    tick();
    rst_n = 1'b1;
    checks++; if (u_if.axi_slv_rvalid !== 1'b0) begin errors++; $display("FAIL mid_rvalid got %0h exp 0", u_if.axi_slv_rvalid); end
    checks++; if (ost_cnt !== 3'd0) begin errors++; $display("FAIL mid_ost got %0d exp 0", ost_cnt); end
    checks++; if (u_if.axi_slv_rid !== 4'h0) begin errors++; $display("FAIL mid_rid got %0h exp 0", u_if.axi_slv_rid); end
    checks++; if (u_if.axi_slv_rdata !== 32'h0) begin errors++; $display("FAIL mid_rdata got %0h exp 0", u_if.axi_slv_rdata); end
    #1;
    checks++; if (u_if.axi_slv_arready !== 1'b1) begin errors++; $display("FAIL mid_arready_release got %0h exp 1", u_if.axi_slv_arready); end
    u_if.axi_slv_rready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if (u_if.axi_slv_rvalid !== 1'b0) begin errors++; $display("FAIL mid_stale[%0d] got %0h exp 0", c, u_if.axi_slv_rvalid); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_error_decode();
    test_fill_full();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/easyaxi_slv_rd.md
Name: easyaxi_slv_rd

Overview:
- AXI read-slave responder that consumes the AR-channel requests produced by the team's read master, and returns a single-beat R response for each accepted request.
- Buffers up to OST_DEPTH outstanding requests in order.
- Each response is delayed by a fixed RD_LATENCY and carries deterministic data derived from the request, so benches can self-check.
- Sits directly downstream of the read master on the same clock.

Parameters:
- AXI_ID_WIDTH, 4: ARID/RID width.
- AXI_ADDR_WIDTH, 16: ARADDR width.
- AXI_DATA_WIDTH, 32: RDATA width. Must be >= AXI_ADDR_WIDTH + AXI_ID_WIDTH.
- OST_DEPTH, 4: maximum outstanding requests. Power of two, >= 2.
- RD_LATENCY, 2: cycles from AR handshake to first RVALID. Legal range 1..15.
- ADDR_LIMIT, 16'h0001: requests with araddr < ADDR_LIMIT get OKAY; all others get SLVERR.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- axi_slv_arvalid  in  1  AR request valid.
- axi_slv_arready  out  1  AR request accept.
- axi_slv_arid  in  AXI_ID_WIDTH  request ID.
- axi_slv_araddr  in  AXI_ADDR_WIDTH  request address.
- axi_slv_rvalid  out  1  R response valid.
- axi_slv_rready  in  1  R response accept.
- axi_slv_rid  out  AXI_ID_WIDTH  response ID; equals the ID of the request being answered.
- axi_slv_rdata  out  AXI_DATA_WIDTH  response data.
- axi_slv_rresp  out  2  00 = OKAY, 10 = SLVERR.
- axi_slv_rlast  out  1  tied to 1 (single-beat bursts).
- ost_cnt  out  $clog2(OST_DEPTH)+1  number of entries currently held.

Behaviour:
- Reset:
  - Sampled at a clk edge with rst_n low.
  - Clears FIFO pointers, count and all countdowns.
  - Outputs while/after reset: rvalid=0, rid=0, rdata=0, rresp=0, ost_cnt=0.
  - arready is forced 0 while rst_n is low, and becomes 1 in the first cycle after reset release.
  - Reset mid-operation discards all outstanding requests without emitting responses.
- AR accept:
  - arready = rst_n & (ost_cnt != OST_DEPTH). Combinational from registered state only; no dependence on arvalid.
  - Handshake when arvalid & arready.
  - On handshake the block pushes {arid, araddr, resp, countdown = RD_LATENCY-1}.
  - resp = OKAY if araddr < ADDR_LIMIT (unsigned), else SLVERR.
- Countdown:
  - Every cycle, each valid entry with countdown > 0 decrements by 1; it saturates at 0.
- R issue:
  - rvalid = FIFO non-empty & head countdown == 0, registered so the response is glitch-free.
  - A handshake at edge E produces rvalid high in the cycle after edge E + RD_LATENCY - 1, i.e. RD_LATENCY cycles after the handshake cycle.
  - Responses are returned strictly in acceptance order; no reordering by ID.
- R payload:
  - rid = head arid.
  - rdata = {zeros, arid, araddr}: araddr in bits [ADDR-1:0], arid in bits [ADDR+ID-1:ADDR], zeros above.
  - rresp = stored resp. rlast = 1.
- R handshake:
  - While rvalid & ~rready, rid/rdata/rresp/rvalid hold stable.
  - On rvalid & rready the head pops.
  - If the next entry's countdown is already 0, rvalid stays 1 the next cycle with the new payload (back-to-back, one response per cycle).
  - Otherwise rvalid drops to 0.
- Simultaneous events:
  - An AR push and an R pop in the same cycle are both performed and ost_cnt is unchanged.
  - When full, arready=0 even if a pop occurs that cycle (no full bypass).
  - A push into an empty FIFO never bypasses the latency.
- Wrap-around: pointers wrap modulo OST_DEPTH; ost_cnt is the authoritative full/empty indicator.
- Not reachable by construction: overflow and underflow (arready and rvalid gate them).

Decomposition:
- easyaxi_define.v holds the shared width constants: AXI_ID_WIDTH, AXI_ADDR_WIDTH, AXI_DATA_WIDTH.
- Add AXI_RESP_OKAY = 2'b00 and AXI_RESP_SLVERR = 2'b10 there.
- One sub-module, easyaxi_sync_fifo:
  - Parameterised width/depth, synchronous active-low reset.
  - Push/pop, full/empty, count.
  - Stores the {id, addr, resp} payload.
- Per-entry countdown registers live in easyaxi_slv_rd alongside the FIFO storage indices.

Test Plan:
- Single request, rready=1:
  - arid=3, araddr=0x0000 accepted in cycle 5.
  - Required: rvalid first high in cycle 7 (RD_LATENCY=2), rid=3, rdata=0x0003_0000, rresp=00, rlast=1.
  - rvalid low in cycle 8.
- Error decode: araddr=0x0001, arid=0xA -> rresp=10, rdata=0x000A_0001.
- Fill to full with rready=0:
  - Four requests accepted with IDs 0..3, then ost_cnt=4 and arready=0.
  - Raise rready: responses rid 0,1,2,3 on four consecutive cycles.
  - arready=1 the cycle after the first pop.
- Back-pressure hold: rready=0 for 5 cycles while rvalid=1 -> rid/rdata/rresp unchanged every cycle.
- Streaming: arvalid=1 continuously and rready=1, IDs 0..15 wrapping -> RIDs in the same order, one per cycle in steady state, ost_cnt steady.
- Reset mid-operation:
  - rst_n low for 1 cycle with 3 entries outstanding.
  - Required: rvalid=0, ost_cnt=0, arready=0 that cycle and 1 the next, no stale responses afterwards.
